fir_coef_loader: RTL
====================

Name: fir_coef_loader

Overview:
- Upstream configuration stage for the {-1,0,+1}-coefficient FIR filter.
- Accepts a full packed coefficient set through a valid/ready handshake.
- Writes the set into the filter one tap per cycle through the filter's coefficient-write port.
- Sanitises reserved codes, flags them, and reports busy/done status to the controlling logic.

Parameters:
- TAP_NUMBER, 10, number of filter taps; must be >= 2 and must match the FIR instance.
- IDX_W, $clog2(TAP_NUMBER), width of the tap index; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock, shared with the FIR.
- rst_n  input  1  synchronous, active-low reset.
- coef_vec_in  input  2*TAP_NUMBER  packed set; tap i in bits [2i+1:2i]; 2'b00=0, 2'b01=+1, 2'b11=-1, 2'b10=reserved.
- coef_vec_valid  input  1  coef_vec_in is valid.
- coef_vec_ready  output  1  loader can accept a set.
- coef_num  output  IDX_W  tap index; drives the FIR Coef_Num.
- coef_val  output  2 signed  coefficient value; drives the FIR Coef_Val.
- coef_w_en  output  1  write strobe; drives the FIR Coef_w_en.
- load_busy  output  1  a set is being written.
- load_done  output  1  one-cycle pulse after the last tap is written.
- code_err  output  1  sticky; the last accepted set contained a reserved code.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- All outputs are registered.
- Reset values (rst_n low at a clk edge):
  - coef_vec_ready=1, coef_w_en=0, coef_num=0, coef_val=2'b00.
  - load_busy=0, load_done=0, code_err=0, FSM=IDLE.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - coef_vec_ready=1.
  - Handshake at edge t (coef_vec_valid & coef_vec_ready): capture coef_vec_in into an internal shadow register, clear tap counter, go to LOAD.
  - At t, code_err is set to 1 if any 2-bit field equals 2'b10, otherwise cleared to 0. It holds that value until the next accepted set.
  - coef_vec_ready drops from edge t onward.
- LOAD:
  - load_busy=1, coef_vec_ready=0.
  - Each cycle k = 0..TAP_NUMBER-1 presents coef_w_en=1, coef_num=k, coef_val=sanitised field k.
  - So the strobe is high in the cycles following edges t..t+TAP_NUMBER-1: exactly TAP_NUMBER consecutive strobe cycles, in ascending tap order, with no gaps.
  - Sanitising: reserved 2'b10 is written as 2'b00; all other codes pass unchanged.
  - After the tap TAP_NUMBER-1 strobe, go to DONE.
- DONE (one cycle):
  - coef_w_en=0, load_busy=0, load_done=1, coef_vec_ready=1.
  - A handshake in this cycle is accepted exactly as in IDLE (back-to-back loads). Next state is LOAD if accepted, otherwise IDLE.
  - load_done is never high for two consecutive cycles.
- Latency: handshake edge t → first write visible after edge t → load_done high in the cycle after edge t+TAP_NUMBER.
  - The FIR uses new coefficients on its next edge after each strobe; its output register adds 1 cycle.
- coef_vec_valid while busy: ignored, not captured. The source must hold the set until ready; changes to coef_vec_in during LOAD have no effect (shadow copy).
- When coef_w_en=0: coef_num and coef_val hold their last values.
- Reset mid-LOAD: the loader returns to reset state on that edge; no further strobes are issued. FIR taps already written keep their new values and the rest keep old values. Software must reload.
- Counter range: the counter never exceeds TAP_NUMBER-1, including non-power-of-2 TAP_NUMBER; no wrap writes.

Test Plan:
- Reset, then load TAP_NUMBER=10 with taps 0..9 = +1,-1,0,+1,+1,0,-1,-1,0,+1 → ready low at t; 10 strobes with coef_num 0..9 and coef_val 01,11,00,01,01,00,11,11,00,01; load_done pulse at cycle t+11; code_err=0.
- Set with tap 3 = 2'b10, others +1 → tap 3 written as 00, code_err=1 and held. A following clean set → code_err=0 at its accept edge.
- valid held high continuously with two different sets → second accepted in the DONE cycle; strobes for the second set start immediately after the 10th strobe of the first, with exactly one strobe-free cycle between them.
- Change coef_vec_in and pulse valid during LOAD → no capture, written values unaffected, ready stays 0 until DONE.
- rst_n low at the 4th strobe → from the next cycle coef_w_en=0, ready=1, load_busy=0, no load_done. FIR model shows taps 0..2 new and the rest old.
- TAP_NUMBER=5 build with all taps -1 → exactly 5 strobes, coef_num 0..4, never 5..7; load_done at t+6. Cross-check the integrated FIR output against a reference model for an impulse input.

Source files
------------

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: accepts a packed {-1,0,+1} coefficient set and
// streams it into the FIR coefficient-write port, one tap per clock.
module fir_coef_loader #(
    parameter int TAP_NUMBER = 10,
    parameter int IDX_W      = $clog2(TAP_NUMBER)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*TAP_NUMBER-1:0] coef_vec_in,
    input  logic                    coef_vec_valid,
    output logic                    coef_vec_ready,
    output logic [IDX_W-1:0]        coef_num,
    output logic signed [1:0]       coef_val,
    output logic                    coef_w_en,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    code_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(TAP_NUMBER - 1);

    state_t                  state;
    logic [2*TAP_NUMBER-1:0] shadow;
    logic [IDX_W-1:0]        next_idx;
    logic                    accept;

    // Reserved code 2'b10 is written to the filter as zero.
    function automatic logic [1:0] sanitise(input logic [1:0] c);
        return (c == 2'b10) ? 2'b00 : c;
    endfunction

    function automatic logic [1:0] field(
        input logic [2*TAP_NUMBER-1:0] v,
        input logic [IDX_W-1:0]        i
    );
        logic [1:0] f;
        f = 2'b00;
        for (int k = 0; k < TAP_NUMBER; k++) begin
            if (i == IDX_W'(k)) f = v[2*k +: 2];
        end
        return f;
    endfunction

    function automatic logic has_reserved(input logic [2*TAP_NUMBER-1:0] v);
        logic r;
        r = 1'b0;
        for (int k = 0; k < TAP_NUMBER; k++) begin
            if (v[2*k +: 2] == 2'b10) r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        accept   = coef_vec_valid & coef_vec_ready;
        next_idx = coef_num + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            shadow         <= '0;
            coef_vec_ready <= 1'b1;
            coef_w_en      <= 1'b0;
            coef_num       <= '0;
            coef_val       <= 2'b00;
            load_busy      <= 1'b0;
            load_done      <= 1'b0;
            code_err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    load_done <= 1'b0;
                    if (accept) begin
                        // Tap 0 comes straight from the input so the first
                        // strobe is visible right after the accept edge.
                        state          <= LOAD;
                        shadow         <= coef_vec_in;
                        coef_vec_ready <= 1'b0;
                        load_busy      <= 1'b1;
                        coef_w_en      <= 1'b1;
                        coef_num       <= '0;
                        coef_val       <= sanitise(coef_vec_in[1:0]);
                        code_err       <= has_reserved(coef_vec_in);
                    end else begin
                        state          <= IDLE;
                        coef_vec_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (coef_num == LAST) begin
                        state          <= DONE;
                        coef_w_en      <= 1'b0;
                        load_busy      <= 1'b0;
                        load_done      <= 1'b1;
                        coef_vec_ready <= 1'b1;
                    end else begin
                        coef_num <= next_idx;
                        coef_val <= sanitise(field(shadow, next_idx));
                    end
                end
                default: begin
                    state          <= IDLE;
                    coef_vec_ready <= 1'b1;
                    coef_w_en      <= 1'b0;
                    load_busy      <= 1'b0;
                    load_done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
